// File: rtl/serial_adder.sv
// Digit-serial add/subtract: one DIGIT-bit full-adder slice with a registered carry, WIDTH/DIGIT cycles per operation.
// Latency N+1 edges from accepted start to done; start is ignored while busy, results are held until the next completion.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] op_a, op_b, psum, psum_nxt;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [DIGIT:0]   slice;
  logic             last, load, msb_cin;

  always_comb begin
    slice    = {1'b0, op_a[DIGIT-1:0]} + {1'b0, op_b[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
    // New digit enters at the MSB end so the final digit lands in the top bits.
    psum_nxt = (psum >> DIGIT) | (WIDTH'(slice[DIGIT-1:0]) << (WIDTH - DIGIT));
    // Carry into the result MSB, recovered from that bit's inputs and sum.
    msb_cin  = op_a[DIGIT-1] ^ op_b[DIGIT-1] ^ slice[DIGIT-1];
    last     = (cnt == CW'(N - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_a  <= '0;
      op_b  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      psum  <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (load) begin
      op_a  <= a;
      op_b  <= sub ? ~b : b;
      carry <= sub ? 1'b1 : cin;
      cnt   <= '0;
      psum  <= '0;
    end else if (state == RUN) begin
      op_a  <= op_a >> DIGIT;
      op_b  <= op_b >> DIGIT;
      carry <= slice[DIGIT];
      cnt   <= cnt + CW'(1);
      psum  <= psum_nxt;
      if (last) begin
        sum  <= psum_nxt;
        cout <= slice[DIGIT];
        ovf  <= msb_cin ^ slice[DIGIT];
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: 8-bit/1-digit instance for directed and random ops,
// plus 4-bit instances with DIGIT=1,2,4 swept exhaustively against an arithmetic model.
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] a8 = '0, b8 = '0, sum8;
  logic       cin8 = 1'b0, sub8 = 1'b0, start8 = 1'b0;
  logic       busy8, done8, cout8, ovf8;

  logic [3:0] a4 = '0, b4 = '0;
  logic       cin4 = 1'b0, sub4 = 1'b0, start4 = 1'b0;
  logic [3:0] sum4 [3];
  logic       busy4 [3], done4 [3], cout4 [3], ovf4 [3];

  int checks = 0;
  int failures = 0;

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8), .sub(sub8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8));

  serial_adder #(.WIDTH(4), .DIGIT(1)) u_dut4_d1 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4), .sub(sub4),
    .busy(busy4[0]), .done(done4[0]), .sum(sum4[0]), .cout(cout4[0]), .ovf(ovf4[0]));

  serial_adder #(.WIDTH(4), .DIGIT(2)) u_dut4_d2 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4), .sub(sub4),
    .busy(busy4[1]), .done(done4[1]), .sum(sum4[1]), .cout(cout4[1]), .ovf(ovf4[1]));

  serial_adder #(.WIDTH(4), .DIGIT(4)) u_dut4_d4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4), .sub(sub4),
    .busy(busy4[2]), .done(done4[2]), .sum(sum4[2]), .cout(cout4[2]), .ovf(ovf4[2]));

  // Arithmetic reference: unsigned result/carry and signed-range overflow.
  function automatic void model(input int w, input int ia, input int ib, input int icin,
                                input int isub, output int s, output int co, output int ov);
    int mask, half, sa, sb, t, tr;
    mask = (1 << w) - 1;
    half = 1 << (w - 1);
    sa = (ia >= half) ? ia - (1 << w) : ia;
    sb = (ib >= half) ? ib - (1 << w) : ib;
    if (isub != 0) begin
      t  = ia - ib;
      co = (ia >= ib) ? 1 : 0;
      tr = sa - sb;
    end else begin
      t  = ia + ib + icin;
      co = (t > mask) ? 1 : 0;
      tr = sa + sb + icin;
    end
    s  = t & mask;
    ov = (tr > half - 1 || tr < -half) ? 1 : 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one 8-bit op and wait for done; lat counts edges from acceptance to done inclusive.
  task automatic run8(input logic [7:0] ia, input logic [7:0] ib, input logic icin, input logic isub,
                      output int lat, output int bcnt, output bit both);
    a8 = ia; b8 = ib; cin8 = icin; sub8 = isub;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    lat = 1; bcnt = 0; both = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (busy8 && done8) both = 1'b1;
      if (done8) break;
      if (busy8) bcnt++;
      tick();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start8 = 1'b1;
    start4 = 1'b1;
    tick(); tick();
    start8 = 1'b0;
    start4 = 1'b0;
    rst_n = 1'b1;
    checks++;
    if ({busy8, done8, sum8, cout8, ovf8} !== 12'h000) begin
      failures++;
      $display("FAIL reset8 got busy=%b done=%b sum=%h cout=%b ovf=%b exp all 0", busy8, done8, sum8, cout8, ovf8);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if ({busy4[k], done4[k], sum4[k], cout4[k], ovf4[k]} !== 8'h00) begin
        failures++;
        $display("FAIL reset4[%0d] got busy=%b done=%b sum=%h cout=%b ovf=%b exp all 0",
                 k, busy4[k], done4[k], sum4[k], cout4[k], ovf4[k]);
      end
    end
    tick();
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle got busy=%b done=%b exp 0 0", busy8, done8);
    end
  endtask

  task automatic test_vectors();
    logic [7:0] va [6] = '{8'h00, 8'hFF, 8'h7F, 8'h05, 8'h80, 8'h05};
    logic [7:0] vb [6] = '{8'h00, 8'h01, 8'h01, 8'h07, 8'h01, 8'h07};
    logic       vc [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic       vs [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [7:0] es [6] = '{8'h01, 8'h00, 8'h80, 8'hFE, 8'h7F, 8'hFE};
    logic       ec [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       eo [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    int lat, bcnt;
    bit both;
    for (int i = 0; i < 6; i++) begin
      run8(va[i], vb[i], vc[i], vs[i], lat, bcnt, both);
      checks++;
      if (lat !== 9 || bcnt !== 8 || both !== 1'b0) begin
        failures++;
        $display("FAIL vec%0d_timing got lat=%0d busy_cycles=%0d overlap=%0d exp 9 8 0", i, lat, bcnt, both);
      end
      checks++;
      if ({sum8, cout8, ovf8} !== {es[i], ec[i], eo[i]}) begin
        failures++;
        $display("FAIL vec%0d_result got sum=%h cout=%b ovf=%b exp sum=%h cout=%b ovf=%b",
                 i, sum8, cout8, ovf8, es[i], ec[i], eo[i]);
      end
    end
    tick();
  endtask

  task automatic test_mid_run_start();
    int lat;
    a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0; sub8 = 1'b0;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; sub8 = 1'b1;
    lat = 1;
    for (int i = 0; i < 40; i++) begin
      if (done8) break;
      start8 = (lat == 3);
      tick();
      lat++;
    end
    start8 = 1'b0;
    checks++;
    if (lat !== 9 || {sum8, cout8, ovf8} !== {8'h46, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL mid_run_start got lat=%0d sum=%h cout=%b ovf=%b exp lat=9 sum=46 cout=0 ovf=0",
               lat, sum8, cout8, ovf8);
    end
    tick();
    checks++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || sum8 !== 8'h46) begin
      failures++;
      $display("FAIL after_done_idle got busy=%b done=%b sum=%h exp 0 0 46", busy8, done8, sum8);
    end
  endtask

  task automatic test_back_to_back();
    int t, t1, t2;
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; sub8 = 1'b0;
    start8 = 1'b1;
    tick();
    t = 1; t1 = -1; t2 = -1;
    for (int i = 0; i < 60; i++) begin
      if (done8) begin
        if (t1 < 0) begin
          t1 = t;
          checks++;
          if ({sum8, cout8, ovf8} !== {8'h30, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL b2b_first got sum=%h cout=%b ovf=%b exp 30 0 0", sum8, cout8, ovf8);
          end
          a8 = 8'h50; b8 = 8'h10; sub8 = 1'b1;
        end else begin
          t2 = t;
        end
      end
      if (t2 >= 0) break;
      tick();
      t++;
    end
    start8 = 1'b0;
    checks++;
    if (t1 !== 9 || t2 - t1 !== 9) begin
      failures++;
      $display("FAIL b2b_spacing got first=%0d gap=%0d exp 9 9", t1, t2 - t1);
    end
    checks++;
    if ({sum8, cout8, ovf8} !== {8'h40, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL b2b_second got sum=%h cout=%b ovf=%b exp 40 1 0", sum8, cout8, ovf8);
    end
    tick();
  endtask

  task automatic test_reset_mid_run();
    int lat, bcnt, dcnt;
    bit both;
    a8 = 8'h21; b8 = 8'h42; cin8 = 1'b0; sub8 = 1'b0;
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if ({busy8, done8, sum8, cout8, ovf8} !== 12'h000) begin
      failures++;
      $display("FAIL reset_mid got busy=%b done=%b sum=%h cout=%b ovf=%b exp all 0", busy8, done8, sum8, cout8, ovf8);
    end
    dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done8 || busy8) dcnt++;
    end
    checks++;
    if (dcnt !== 0) begin
      failures++;
      $display("FAIL reset_abort got active_cycles=%0d exp 0", dcnt);
    end
    run8(8'h21, 8'h42, 1'b0, 1'b0, lat, bcnt, both);
    checks++;
    if (lat !== 9 || {sum8, cout8, ovf8} !== {8'h63, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_recover got lat=%0d sum=%h cout=%b ovf=%b exp 9 63 0 0", lat, sum8, cout8, ovf8);
    end
    tick();
  endtask

  task automatic test_random();
    int lat, bcnt, es, ec, eo;
    bit both;
    logic [7:0] ra, rb;
    logic rc, rs;
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      model(8, int'(ra), int'(rb), int'(rc), int'(rs), es, ec, eo);
      run8(ra, rb, rc, rs, lat, bcnt, both);
      checks++;
      if (lat !== 9 || int'(sum8) !== es || int'(cout8) !== ec || int'(ovf8) !== eo) begin
        failures++;
        $display("FAIL random a=%h b=%h cin=%b sub=%b got lat=%0d sum=%h cout=%b ovf=%b exp lat=9 sum=%h cout=%0d ovf=%0d",
                 ra, rb, rc, rs, lat, sum8, cout8, ovf8, es, ec, eo);
      end
    end
    tick();
  endtask

  task automatic test_sweep4();
    int exp_lat [3] = '{5, 3, 2};
    int lat [3];
    logic [3:0] gs [3];
    logic gc [3], go [3];
    int es, ec, eo;
    for (int op = 0; op < 1024; op++) begin
      a4 = 4'(op & 15);
      b4 = 4'((op >> 4) & 15);
      cin4 = 1'((op >> 8) & 1);
      sub4 = 1'((op >> 9) & 1);
      model(4, int'(a4), int'(b4), int'(cin4), int'(sub4), es, ec, eo);
      start4 = 1'b1;
      tick();
      start4 = 1'b0;
      for (int k = 0; k < 3; k++) lat[k] = 0;
      for (int step = 0; step < 8; step++) begin
        for (int k = 0; k < 3; k++) begin
          if (done4[k] && lat[k] == 0) begin
            lat[k] = step + 1;
            gs[k] = sum4[k];
            gc[k] = cout4[k];
            go[k] = ovf4[k];
          end
        end
        tick();
      end
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (lat[k] !== exp_lat[k] || int'(gs[k]) !== es || int'(gc[k]) !== ec || int'(go[k]) !== eo) begin
          failures++;
          $display("FAIL sweep4_d%0d a=%h b=%h cin=%b sub=%b got lat=%0d sum=%h cout=%b ovf=%b exp lat=%0d sum=%h cout=%0d ovf=%0d",
                   1 << k, a4, b4, cin4, sub4, lat[k], gs[k], gc[k], go[k], exp_lat[k], es, ec, eo);
        end
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_vectors();
    test_mid_run_start();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    test_sweep4();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Parametrised, bit-serial successor to the single-bit full adder. Adds or subtracts two WIDTH-bit operands, DIGIT bits per clock, through one DIGIT-bit full-adder slice with a registered carry. Start/busy/done handshake; results held in output registers. Serves as the area-minimal arithmetic unit for datapaths that can tolerate multi-cycle latency.

## Interface
- WIDTH, 8: operand and result width. Must be ≥ 2 and an integer multiple of DIGIT.
- DIGIT, 1: bits processed per clock. N = WIDTH/DIGIT is the cycle count per operation.
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  request; sampled only in IDLE or DONE.
- a  in  WIDTH  operand A (unsigned or two's complement); captured when start is accepted.
- b  in  WIDTH  operand B; captured when start is accepted.
- cin  in  1  carry-in for add; ignored when sub=1.
- sub  in  1  mode select captured with start: 0 = A+B+cin, 1 = A−B (A + ~B + 1).
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; high in the DONE state.
- sum  out  WIDTH  result register.
- cout  out  1  carry out of the MSB. For sub, 1 means no borrow (A ≥ B unsigned).
- ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE, start=1:
  - Load opA←a and opB←(sub ? ~b : b).
  - Load carry←(sub ? 1 : cin).
  - Clear digit counter; go to RUN.
- RUN, each cycle:
  - Add the low DIGIT bits of opA, opB and carry.
  - Shift the DIGIT-bit result into a partial-sum shift register from the MSB end.
  - Shift opA and opB right by DIGIT. Update carry.
  - On the last digit (counter = N−1), also capture the carry into the MSB position (for ovf); go to DONE.
- Internal arithmetic is WIDTH bits; no value wraps except the carry out of bit WIDTH−1, which goes to cout.
- DONE:
  - The sum, cout and ovf registers were written on the edge that entered DONE.
  - done=1 for exactly this cycle.
  - start=1 here is accepted as in IDLE (back-to-back). Otherwise go to IDLE.
- start while in RUN is ignored. There is no queueing and no error flag.
- sum, cout and ovf change only on the edge entering DONE, and hold until the next completion. A zero-cycle update never occurs.
- Inputs a, b, cin and sub may change freely after acceptance without affecting the operation in flight.

## Timing
- Start accepted at edge E0. Digit i is processed at edge E(i+1), for i = 0..N−1.
- Results are visible and done=1 after edge E(N): a latency of N+1 edges from start to done.
- busy=1 after E0 through E(N−1); busy=0 when done=1. busy and done are never high together.
- Back-to-back: start held high in the DONE cycle re-enters RUN at the next edge. Throughput is one result per N+1 cycles.
- Reset: rst_n=0 at any edge forces the following, regardless of start:
  - IDLE, busy=0, done=0, sum=0, cout=0, ovf=0.
  - Internal operand, carry and counter registers are cleared.
- Reset mid-RUN aborts the operation: no done pulse, and the outputs read 0.

## Test plan
- WIDTH=8, DIGIT=1; reset, then a=0x00, b=0x00, cin=1, sub=0, start for 1 cycle → busy for 8 cycles; done after 9 edges; sum=0x01, cout=0, ovf=0.
- a=0xFF, b=0x01, add → sum=0x00, cout=1, ovf=0. Next: a=0x7F, b=0x01 → sum=0x80, cout=0, ovf=1.
- sub=1, a=0x05, b=0x07 → sum=0xFE, cout=0, ovf=0. Next: a=0x80, b=0x01 → sum=0x7F, cout=1, ovf=1. Hold cin=1 during sub → no effect.
- start pulsed mid-RUN, with a and b changed right after acceptance → ignored, original result returned. start held high in DONE → second op begins; done pulses exactly N+1 edges apart.
- rst_n=0 for one edge at digit 4 of a run → no done pulse; all outputs 0; a subsequent start completes normally.
- WIDTH=4 with DIGIT=1, 2 and 4: exhaustive a, b, cin and sub sweep against a behavioural model; latency 5, 3 and 2 edges respectively.
